// File: rtl/adc_packetizer.sv
// ---------------------------------------------------------------------------
// adc_packetizer
//
// Captures multi-channel ADC frames into a frame FIFO and streams them out as
// byte packets: a 4-byte header (0xA5, channel mask, sequence number MSB/LSB)
// followed by PKT_SAMPLES frames. Each frame carries only the enabled channels,
// in ascending order, as 16-bit sign-extended samples sent MSB first.
//
// State table
//   capture FSM
//     IDLE    | waiting for start; FIFO empty
//     CAPTURE | din_valid frames are written to the FIFO
//     DRAIN   | capture halted; finishing any complete packet still queued
//   transmit FSM
//     TX_IDLE | fewer than PKT_SAMPLES frames queued
//     TX_HDR  | sending the 4 header bytes
//     TX_PAY  | sending payload bytes
//
// Ports
//   clk, rstn             clock, synchronous active-low reset
//   start, stop           single-cycle capture control pulses
//   ch_mask               channel enable, latched on start
//   din, din_valid        one frame of NUM_CH samples per valid cycle
//   tx_data/valid/ready   byte stream with valid/ready handshake
//   tx_last               final byte of a packet
//   busy                  capture or transmit in progress
//   overflow              sticky: a frame was dropped on a full FIFO
//   pkt_count             sequence number of the next packet
// ---------------------------------------------------------------------------
module adc_packetizer #(
    parameter int NUM_CH      = 4,
    parameter int SAMPLE_W    = 14,
    parameter int PKT_SAMPLES = 256,
    parameter int FIFO_DEPTH  = 1024
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic                         stop,
    input  logic [NUM_CH-1:0]            ch_mask,
    input  logic [NUM_CH*SAMPLE_W-1:0]   din,
    input  logic                         din_valid,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         tx_last,
    output logic                         busy,
    output logic                         overflow,
    output logic [15:0]                  pkt_count
);

    localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW      = $clog2(FIFO_DEPTH + 1);
    localparam int CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FCW     = (PKT_SAMPLES > 1) ? $clog2(PKT_SAMPLES) : 1;
    localparam int FRAME_W = NUM_CH * 16;

    localparam logic [CW-1:0]  PKT_THR     = CW'(PKT_SAMPLES);
    localparam logic [CW-1:0]  FIFO_FULL   = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0]  PTR_MAX     = AW'(FIFO_DEPTH - 1);
    localparam logic [FCW-1:0] FRAMES_INIT = FCW'(PKT_SAMPLES - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN}    cap_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_PAY} tx_state_t;

    cap_state_t         cap_state_q, cap_state_d;
    tx_state_t          tx_state_q, tx_state_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic               overflow_q, overflow_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [CHW-1:0]     ch_q, ch_d;
    logic               hi_q, hi_d;
    logic [FCW-1:0]     frames_left_q, frames_left_d;
    logic [15:0]        pkt_count_q, pkt_count_d;

    logic [FRAME_W-1:0] mem_q [FIFO_DEPTH];

    logic               xfer;
    logic               frame_end;
    logic               pop;
    logic               wr_en;
    logic               flush;
    logic [FRAME_W-1:0] wr_frame;
    logic [FRAME_W-1:0] head;
    logic [15:0]        sample;
    logic [CHW-1:0]     first_ch;
    logic [CHW-1:0]     next_ch;
    logic               has_next;

    // Samples are stored already widened to 16 bits.
    always_comb begin
        wr_frame = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_frame[i*16 +: 16] = 16'($signed(din[i*SAMPLE_W +: SAMPLE_W]));
        end
    end

    // Lowest enabled channel, and the next enabled channel above ch_q.
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        has_next = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_ch = CHW'(i);
                if (CHW'(i) > ch_q) begin
                    next_ch  = CHW'(i);
                    has_next = 1'b1;
                end
            end
        end
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        sample = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (CHW'(i) == ch_q) begin
                sample = head[i*16 +: 16];
            end
        end
    end

    assign tx_valid  = (tx_state_q != TX_IDLE);
    assign xfer      = tx_valid && tx_ready;
    assign frame_end = (tx_state_q == TX_PAY) && !hi_q && !has_next;
    assign pop       = frame_end && xfer;
    assign tx_last   = frame_end && (frames_left_q == '0);
    assign busy      = (cap_state_q != IDLE) || (tx_state_q != TX_IDLE);
    assign overflow  = overflow_q;
    assign pkt_count = pkt_count_q;

    // Capture FSM. A write into a full FIFO still succeeds when a pop frees
    // the head slot in the same cycle.
    always_comb begin
        cap_state_d = cap_state_q;
        mask_d      = mask_q;
        overflow_d  = overflow_q;
        flush       = 1'b0;
        wr_en       = 1'b0;
        case (cap_state_q)
            IDLE: begin
                if (start && !stop && (ch_mask != '0)) begin
                    cap_state_d = CAPTURE;
                    mask_d      = ch_mask;
                    overflow_d  = 1'b0;
                    flush       = 1'b1;
                end
            end
            CAPTURE: begin
                if (din_valid) begin
                    if ((count_q != FIFO_FULL) || pop) begin
                        wr_en = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (stop) begin
                    cap_state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((count_q < PKT_THR) && (tx_state_q == TX_IDLE)) begin
                    cap_state_d = IDLE;
                    flush       = 1'b1;
                end
            end
            default: cap_state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + AW'(1);
            end
            if (wr_en && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!wr_en && pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Transmit FSM. frames_left counts down to the last frame of the packet;
    // after the final byte the post-pop occupancy decides whether the next
    // header follows immediately.
    always_comb begin
        tx_state_d    = tx_state_q;
        byte_idx_d    = byte_idx_q;
        ch_d          = ch_q;
        hi_d          = hi_q;
        frames_left_d = frames_left_q;
        pkt_count_d   = pkt_count_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (count_q >= PKT_THR) begin
                    tx_state_d = TX_HDR;
                    byte_idx_d = '0;
                end
            end
            TX_HDR: begin
                if (xfer) begin
                    if (byte_idx_q == 2'd3) begin
                        tx_state_d    = TX_PAY;
                        ch_d          = first_ch;
                        hi_d          = 1'b1;
                        frames_left_d = FRAMES_INIT;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            TX_PAY: begin
                if (xfer) begin
                    if (hi_q) begin
                        hi_d = 1'b0;
                    end else if (has_next) begin
                        ch_d = next_ch;
                        hi_d = 1'b1;
                    end else if (frames_left_q == '0) begin
                        pkt_count_d = pkt_count_q + 16'd1;
                        byte_idx_d  = '0;
                        tx_state_d  = (count_d >= PKT_THR) ? TX_HDR : TX_IDLE;
                    end else begin
                        frames_left_d = frames_left_q - FCW'(1);
                        ch_d          = first_ch;
                        hi_d          = 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_data = 8'h00;
        case (tx_state_q)
            TX_HDR: begin
                case (byte_idx_q)
                    2'd0:    tx_data = 8'hA5;
                    2'd1:    tx_data = 8'(mask_q);
                    2'd2:    tx_data = pkt_count_q[15:8];
                    default: tx_data = pkt_count_q[7:0];
                endcase
            end
            TX_PAY:  tx_data = hi_q ? sample[15:8] : sample[7:0];
            default: tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cap_state_q   <= IDLE;
            tx_state_q    <= TX_IDLE;
            mask_q        <= '0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            byte_idx_q    <= '0;
            ch_q          <= '0;
            hi_q          <= 1'b0;
            frames_left_q <= '0;
            pkt_count_q   <= '0;
        end else begin
            cap_state_q   <= cap_state_d;
            tx_state_q    <= tx_state_d;
            mask_q        <= mask_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            byte_idx_q    <= byte_idx_d;
            ch_q          <= ch_d;
            hi_q          <= hi_d;
            frames_left_q <= frames_left_d;
            pkt_count_q   <= pkt_count_d;
        end
    end

    // Frame storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_frame;
        end
    end

endmodule

// File: tb/tb_adc_packetizer.sv
module tb_adc_packetizer;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        stop;
    logic [3:0]  ch_mask;
    logic [55:0] din;
    logic        din_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        busy;
    logic        overflow;
    logic [15:0] pkt_count;

    adc_packetizer #(
        .NUM_CH     (4),
        .SAMPLE_W   (14),
        .PKT_SAMPLES(4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .stop     (stop),
        .ch_mask  (ch_mask),
        .din      (din),
        .din_valid(din_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_last  (tx_last),
        .busy     (busy),
        .overflow (overflow),
        .pkt_count(pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    bit         tog_en   = 1'b0;

    logic [7:0] rx_q[$];
    bit         rxl_q[$];
    logic [7:0] exp_q[$];
    bit         exp_last_q[$];

    int         stall_seen = 0;
    int         hold_bad   = 0;
    bit         stall_pend = 1'b0;
    logic [7:0] held_data  = 8'h00;
    logic       held_last  = 1'b0;

    // Inputs change 1 ns after posedge, so negedge sees the values the next
    // posedge will act on.
    always @(negedge clk) begin
        if (rstn && tx_valid && tx_ready) begin
            rx_q.push_back(tx_data);
            rxl_q.push_back(tx_last);
        end
        if (rstn && stall_pend && tx_valid) begin
            stall_seen++;
            if ((tx_data !== held_data) || (tx_last !== held_last)) hold_bad++;
        end
        stall_pend = rstn && tx_valid && !tx_ready;
        held_data  = tx_data;
        held_last  = tx_last;
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (tog_en) tx_ready = ~tx_ready;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic pulse_start(input logic [3:0] m);
        ch_mask = m;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic send_frame(input logic [13:0] c0, input logic [13:0] c1,
                              input logic [13:0] c2, input logic [13:0] c3);
        din       = {c3, c2, c1, c0};
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int target, input string tag);
        int n = 0;
        while ((rx_q.size() < target) && (n < 400)) begin
            tick();
            n++;
        end
        if (rx_q.size() < target) check({tag, "_timeout"}, rx_q.size(), target);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        while (busy && (n < 100)) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic exp_clear();
        exp_q.delete();
        exp_last_q.delete();
    endtask

    task automatic exp_push(input logic [7:0] b, input bit l);
        exp_q.push_back(b);
        exp_last_q.push_back(l);
    endtask

    task automatic check_stream(input string tag, input int base);
        check({tag, "_len"}, rx_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            int unsigned gb;
            int unsigned gl;
            if (base + i < rx_q.size()) begin
                gb = rx_q[base + i];
                gl = rxl_q[base + i];
            end else begin
                gb = 32'h100;
                gl = 2;
            end
            check($sformatf("%s_byte%0d", tag, i), gb, exp_q[i]);
            check($sformatf("%s_last%0d", tag, i), gl, exp_last_q[i]);
        end
    endtask

    // Basic 0b0101 packet: ch0=0x1FFF -> 1F FF, ch2=0x2000 (-8192) -> E0 00.
    task automatic exp_basic();
        exp_clear();
        exp_push(8'hA5, 0); exp_push(8'h05, 0); exp_push(8'h00, 0); exp_push(8'h00, 0);
        for (int f = 0; f < 4; f++) begin
            exp_push(8'h1F, 0); exp_push(8'hFF, 0); exp_push(8'hE0, 0);
            exp_push(8'h00, f == 3);
        end
    endtask

    int base;
    int stalls0;
    int bad0;
    int n;

    initial begin
        rstn      = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        ch_mask   = 4'h0;
        din       = '0;
        din_valid = 1'b0;
        tx_ready  = 1'b0;
        tick();
        tick();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_last", tx_last, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_pkt_count", pkt_count, 16'h0000);
        rstn = 1'b1;
        tick();

        // Basic packet
        tx_ready = 1'b1;
        base = rx_q.size();
        pulse_start(4'b0101);
        check("t1_busy", busy, 1);
        for (int k = 0; k < 4; k++) send_frame(14'h1FFF, 14'h0AAA, 14'h2000, 14'h1555);
        tick();
        check("t1_valid_latency", tx_valid, 1);
        wait_bytes(base + 20, "t1");
        tick();
        exp_basic();
        check_stream("t1", base);
        check("t1_pkt_count", pkt_count, 16'h0001);
        wait_idle("t1");

        // Backpressure
        do_reset();
        tx_ready = 1'b0;
        tog_en   = 1'b1;
        stalls0  = stall_seen;
        bad0     = hold_bad;
        base     = rx_q.size();
        pulse_start(4'b0101);
        for (int k = 0; k < 4; k++) send_frame(14'h1FFF, 14'h0AAA, 14'h2000, 14'h1555);
        wait_bytes(base + 20, "t2");
        tog_en   = 1'b0;
        tx_ready = 1'b1;
        tick();
        exp_basic();
        check_stream("t2", base);
        check("t2_stalls_seen", (stall_seen > stalls0) ? 1 : 0, 1);
        check("t2_hold_stable", hold_bad - bad0, 0);
        wait_idle("t2");

        // Overflow: 9 frames into a depth-8 FIFO with the sink blocked
        do_reset();
        tx_ready = 1'b0;
        base     = rx_q.size();
        pulse_start(4'b0101);
        for (int k = 1; k <= 8; k++) send_frame(14'h0100 + 14'(k), 14'h0AAA, 14'h3F00 + 14'(k), 14'h1555);
        check("t3_ovf_after8", overflow, 0);
        send_frame(14'h0109, 14'h0AAA, 14'h3F09, 14'h1555);
        check("t3_ovf_after9", overflow, 1);
        tx_ready = 1'b1;
        wait_bytes(base + 40, "t3");
        exp_clear();
        for (int p = 0; p < 2; p++) begin
            exp_push(8'hA5, 0); exp_push(8'h05, 0); exp_push(8'h00, 0); exp_push(8'(p), 0);
            for (int f = 1; f <= 4; f++) begin
                exp_push(8'h01, 0); exp_push(8'(p * 4 + f), 0);
                exp_push(8'hFF, 0); exp_push(8'(p * 4 + f), f == 4);
            end
        end
        for (int k = 0; k < 5; k++) tick();
        check_stream("t3", base);
        check("t3_no_third_pkt", tx_valid, 0);
        check("t3_ovf_sticky", overflow, 1);
        check("t3_pkt_count", pkt_count, 16'h0002);
        wait_idle("t3");

        // Stop and drain: 6 frames, one packet, residual 2 frames discarded
        do_reset();
        tx_ready = 1'b1;
        base     = rx_q.size();
        pulse_start(4'b0011);
        for (int k = 1; k <= 6; k++) send_frame(14'h0010 + 14'(k), 14'h2000 + 14'(k), 14'h0AAA, 14'h0AAA);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_bytes(base + 20, "t4");
        n = 0;
        while (busy && (n < 3)) begin
            tick();
            n++;
        end
        check("t4_busy_drop", busy, 0);
        for (int k = 0; k < 10; k++) tick();
        exp_clear();
        exp_push(8'hA5, 0); exp_push(8'h03, 0); exp_push(8'h00, 0); exp_push(8'h00, 0);
        for (int f = 1; f <= 4; f++) begin
            exp_push(8'h00, 0); exp_push(8'(16 + f), 0);
            exp_push(8'hE0, 0); exp_push(8'(f), f == 4);
        end
        check_stream("t4", base);
        check("t4_pkt_count", pkt_count, 16'h0001);
        pulse_start(4'b0011);
        for (int k = 1; k <= 3; k++) send_frame(14'h0001, 14'h0002, 14'h0003, 14'h0004);
        for (int k = 0; k < 6; k++) tick();
        check("t4_fifo_empty_on_restart", tx_valid, 0);
        wait_idle("t4");

        // Reset during payload byte 7
        do_reset();
        tx_ready = 1'b1;
        base     = rx_q.size();
        pulse_start(4'b0101);
        for (int k = 0; k < 4; k++) send_frame(14'h1FFF, 14'h0AAA, 14'h2000, 14'h1555);
        wait_bytes(base + 10, "t5");
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("t5_tx_valid", tx_valid, 0);
        check("t5_pkt_count", pkt_count, 16'h0000);
        check("t5_busy", busy, 0);
        check("t5_tx_data", tx_data, 8'h00);
        for (int k = 0; k < 6; k++) tick();
        check("t5_no_resume", tx_valid, 0);

        // Ignored start conditions
        pulse_start(4'b0000);
        tick();
        check("t6_mask0_busy", busy, 0);
        ch_mask = 4'b0101;
        start   = 1'b1;
        stop    = 1'b1;
        tick();
        start   = 1'b0;
        stop    = 1'b0;
        tick();
        check("t6_start_stop_busy", busy, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("t6_stop_idle_busy", busy, 0);

        // Sequence wrap with a preloaded counter
        do_reset();
        force dut.pkt_count_q = 16'hFFFF;
        tick();
        tick();
        release dut.pkt_count_q;
        tick();
        check("t7_preload", pkt_count, 16'hFFFF);
        tx_ready = 1'b1;
        base     = rx_q.size();
        pulse_start(4'b0001);
        for (int k = 1; k <= 8; k++) send_frame(14'(k), 14'h0AAA, 14'h0AAA, 14'h0AAA);
        wait_bytes(base + 24, "t7");
        for (int k = 0; k < 3; k++) tick();
        exp_clear();
        exp_push(8'hA5, 0); exp_push(8'h01, 0); exp_push(8'hFF, 0); exp_push(8'hFF, 0);
        for (int f = 1; f <= 4; f++) begin
            exp_push(8'h00, 0); exp_push(8'(f), f == 4);
        end
        exp_push(8'hA5, 0); exp_push(8'h01, 0); exp_push(8'h00, 0); exp_push(8'h00, 0);
        for (int f = 5; f <= 8; f++) begin
            exp_push(8'h00, 0); exp_push(8'(f), f == 8);
        end
        check_stream("t7", base);
        check("t7_pkt_count", pkt_count, 16'h0001);
        wait_idle("t7");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
